// File: rtl/axi_stream_remove_header.sv
// Strips a per-packet header of S = byte_strip_cnt+1 bytes from an MSB-first AXI-style stream.
// Optional header capture port set is enabled by defining REMOVE_HEADER_CAPTURE_EN.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD/8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
`ifdef REMOVE_HEADER_CAPTURE_EN
  output logic                    hdr_valid,
  output logic [DATA_WD-1:0]      hdr_data,
  output logic [DATA_BYTE_WD-1:0] hdr_keep,
`endif
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_strip
);
  localparam int W  = DATA_BYTE_WD;
  localparam int CW = BYTE_CNT_WD + 1;

  typedef logic [CW:0] cnt_t;
  typedef enum logic [1:0] {IDLE, FIRST, STREAM, TAIL} state_e;

  localparam cnt_t W_C = cnt_t'(W);

  function automatic logic [W-1:0] top_ones(input cnt_t n);
    logic [W-1:0] ones;
    ones = '1;
    return ~(ones >> n);
  endfunction

  function automatic logic [DATA_WD-1:0] expand(input logic [W-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < W; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic cnt_t popcnt(input logic [W-1:0] k);
    cnt_t c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + cnt_t'(k[i]);
    return c;
  endfunction

  state_e             state_q, state_d;
  cnt_t               s_q, s_d, tail_q, tail_d;
  logic [DATA_WD-1:0] res_q, res_d, data_q, data_d;
  logic [W-1:0]       keep_q, keep_d;
  logic               valid_q, valid_d, last_q, last_d;

  logic               hs_in, out_free;
  logic [DATA_WD-1:0] din_m, din_shl, merged;
  cnt_t               l_cnt, r_cnt, sum;

  // Masking invalid input bytes up front keeps every derived output byte zero outside keep.
  assign din_m    = data_in & expand(keep_in);
  assign l_cnt    = popcnt(keep_in);
  assign r_cnt    = W_C - s_q;
  assign sum      = r_cnt + l_cnt;
  assign din_shl  = din_m << {s_q, 3'b000};
  assign merged   = res_q | (din_m >> {r_cnt, 3'b000});
  assign out_free = !valid_q || ready_out;
  assign hs_in    = valid_in && ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_strip) state_d = FIRST;
      FIRST:   if (hs_in) state_d = last_in ? IDLE : STREAM;
      STREAM:  if (hs_in && last_in) state_d = (sum <= W_C) ? IDLE : TAIL;
      TAIL:    if (out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready_strip is qualified by rst_n so it reads 0 while reset is held.
  always_comb begin
    ready_in    = ((state_q == FIRST) || (state_q == STREAM)) && out_free;
    ready_strip = (state_q == IDLE) && rst_n;
  end

  always_comb begin
    valid_d = valid_q & ~ready_out;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    res_d   = res_q;
    tail_d  = tail_q;
    s_d     = s_q;
    case (state_q)
      IDLE: if (valid_strip) s_d = cnt_t'(byte_strip_cnt) + cnt_t'(1);
      FIRST: if (hs_in) begin
        res_d = last_in ? '0 : din_shl;
        if (last_in && (l_cnt > s_q)) begin
          valid_d = 1'b1;
          data_d  = din_shl;
          keep_d  = top_ones(l_cnt - s_q);
          last_d  = 1'b1;
        end
      end
      STREAM: if (hs_in) begin
        valid_d = 1'b1;
        data_d  = merged;
        keep_d  = '1;
        last_d  = 1'b0;
        res_d   = din_shl;
        if (last_in) begin
          if (sum <= W_C) begin
            keep_d = top_ones(sum);
            last_d = 1'b1;
            res_d  = '0;
          end else begin
            tail_d = sum - W_C;
          end
        end
      end
      TAIL: if (out_free) begin
        valid_d = 1'b1;
        data_d  = res_q;
        keep_d  = top_ones(tail_q);
        last_d  = 1'b1;
        res_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      res_q   <= '0;
      tail_q  <= '0;
      s_q     <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      res_q   <= res_d;
      tail_q  <= tail_d;
      s_q     <= s_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

`ifdef REMOVE_HEADER_CAPTURE_EN
  logic               hdr_valid_q;
  logic [DATA_WD-1:0] hdr_data_q;
  logic [W-1:0]       hdr_keep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= '0;
      hdr_keep_q  <= '0;
    end else begin
      hdr_valid_q <= (state_q == FIRST) && hs_in;
      if ((state_q == FIRST) && hs_in) begin
        hdr_data_q <= din_m & expand(top_ones(s_q));
        hdr_keep_q <= top_ones(s_q);
      end
    end
  end

  assign hdr_valid = hdr_valid_q;
  assign hdr_data  = hdr_data_q;
  assign hdr_keep  = hdr_keep_q;
`endif
endmodule

// File: doc/axi_stream_remove_header.md
AXI_STREAM_REMOVE_HEADER -- requirements
Module: axi_stream_remove_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, stream data width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), strip-count width.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have ports valid_in (input, 1), data_in (input, DATA_WD), keep_in (input, DATA_BYTE_WD), last_in (input, 1) and ready_in (output, 1), forming the packet input stream.
REQ-007 SHALL have ports valid_out (output, 1), data_out (output, DATA_WD), keep_out (output, DATA_BYTE_WD), last_out (output, 1) and ready_out (input, 1), forming the stripped output stream.
REQ-008 SHALL have ports valid_strip (input, 1), byte_strip_cnt (input, BYTE_CNT_WD) and ready_strip (output, 1), forming the per-packet strip command; strip length S = byte_strip_cnt+1 bytes.

Function
REQ-009 SHALL treat data as MSB-first: byte DATA_BYTE_WD-1 is the earliest byte; keep is MSB-contiguous; non-last input beats carry all-ones keep; last input beat carries L >= 1 bytes.
REQ-010 SHALL implement states IDLE, FIRST, STREAM and TAIL.
REQ-011 IDLE: ready_in=0; on valid_strip, SHALL assert ready_strip in the same cycle, latch S, and go to FIRST.
REQ-012 FIRST: on input handshake, SHALL discard the top S bytes and store the remaining W-S bytes (W=DATA_BYTE_WD) as residue, left-aligned; no output beat.
REQ-013 STREAM: each accepted beat SHALL produce one output beat = residue (top W-S bytes) OR incoming top S bytes; the incoming low W-S bytes become the new residue.
REQ-014 On accepted last beat with residue R=W-S bytes plus L bytes: if R+L <= W, emit one beat with keep = R+L top ones and last_out=1, then go to IDLE; else emit a full beat, go to TAIL.
REQ-015 TAIL: ready_in=0; SHALL emit the residue of R+L-W bytes with last_out=1, then go to IDLE.
REQ-016 Packet whose first beat is also last with L <= S SHALL produce no output and return to IDLE; L > S SHALL emit one beat of L-S bytes with last_out=1.
REQ-017 When S=W, residue is empty; output beats SHALL equal subsequent input beats unchanged.
REQ-018 Outputs SHALL be registered; an output beat appears the cycle after the producing input handshake (TAIL beat the cycle after the prior beat leaves).
REQ-019 ready_in SHALL be high only in FIRST/STREAM when the output register is empty or ready_out=1 (combinational through-path permitted); sustained throughput one beat per cycle.
REQ-020 valid_out SHALL stay high with data/keep/last stable until ready_out=1.
REQ-021 Bytes outside keep_out SHALL be driven to zero.
REQ-022 ready_strip SHALL be 0 outside IDLE; a valid_strip arriving mid-packet SHALL wait.

Reset
REQ-023 On rst_n low, state SHALL become IDLE, valid_out, last_out, ready_in, ready_strip SHALL be 0, data_out, keep_out and residue SHALL be 0, immediately and asynchronously.
REQ-024 Reset mid-packet SHALL discard the partial packet; after release the block SHALL wait for a new strip command.

Configuration
REQ-025 Macro REMOVE_HEADER_CAPTURE_EN: when defined, SHALL add outputs hdr_valid (1), hdr_data (DATA_WD) and hdr_keep (DATA_BYTE_WD), pulsing hdr_valid for one cycle after the FIRST handshake with stripped bytes left-aligned and keep = top S ones; when undefined, these ports and their registers SHALL not exist.

Verification
REQ-026 S=1, three beats 0xA1A2A3A4, 0xB1B2B3B4, 0xC1C2C3C4 (keep 1111/1111/1100) -> 0xA2A3A4B1 keep 1111, 0xB2B3B4C1 keep 1111, 0xC2000000 keep 1000 last.
REQ-027 S=2, beats 0x11223344, 0x55667788 (last, keep 1111) -> 0x33445566 keep 1111, then TAIL 0x77880000 keep 1100 last, ready_in=0 during TAIL.
REQ-028 S=4, beats 0xDEADBEEF, 0x01020304 (last, keep 1110) -> single beat 0x01020300 keep 1110 last.
REQ-029 S=3, single beat 0xAABBCCDD keep 1100 last -> no output; ready_strip accepts next command.
REQ-030 Back-to-back packets with ready_out toggling 1010 -> no byte lost or duplicated, output held stable while ready_out=0.
REQ-031 rst_n low mid-STREAM -> valid_out=0 immediately; next packet after release stripped correctly.
